// File: rtl/la_isa_pkg.sv
// Shared LA32R encoder definitions: unit selects, micro-op codes, major opcodes and
// immediate range checks used by encode_loongarch and encode_loongarch_comb.
package la_isa_pkg;

  typedef enum logic [0:0] {S_IDLE, S_SPLIT_LO} enc_state_e;

  localparam int unsigned FU_ALU_BIT = 0;
  localparam int unsigned FU_MDU_BIT = 1;
  localparam int unsigned FU_BR_BIT  = 2;
  localparam int unsigned FU_LS_BIT  = 3;
  localparam int unsigned FU_CSR_BIT = 4;

  localparam logic [6:0] FT_ALU = 7'(1 << FU_ALU_BIT);
  localparam logic [6:0] FT_MDU = 7'(1 << FU_MDU_BIT);
  localparam logic [6:0] FT_BR  = 7'(1 << FU_BR_BIT);
  localparam logic [6:0] FT_LS  = 7'(1 << FU_LS_BIT);
  localparam logic [6:0] FT_CSR = 7'(1 << FU_CSR_BIT);

  // ALU register-register uops equal the op5 field of the 3R encoding.
  localparam logic [5:0] UOP_ADD   = 6'd0,  UOP_SUB   = 6'd2,  UOP_SLT   = 6'd4;
  localparam logic [5:0] UOP_SLTU  = 6'd5,  UOP_NOR   = 6'd8,  UOP_AND   = 6'd9;
  localparam logic [5:0] UOP_OR    = 6'd10, UOP_XOR   = 6'd11, UOP_SLL   = 6'd14;
  localparam logic [5:0] UOP_SRL   = 6'd15, UOP_SRA   = 6'd16;
  localparam logic [5:0] UOP_ADDI  = 6'h20, UOP_SLTI  = 6'h21, UOP_SLTUI = 6'h22;
  localparam logic [5:0] UOP_ANDI  = 6'h23, UOP_ORI   = 6'h24, UOP_XORI  = 6'h25;
  localparam logic [5:0] UOP_SLLI  = 6'h28, UOP_SRLI  = 6'h29, UOP_SRAI  = 6'h2a;
  localparam logic [5:0] UOP_LU12I = 6'h30;

  localparam logic [5:0] UOP_BEQ  = 6'd0, UOP_BGEU = 6'd5, UOP_BEQZ = 6'd6, UOP_BNEZ = 6'd7;
  localparam logic [5:0] UOP_B    = 6'd8, UOP_BL   = 6'd9, UOP_JIRL = 6'd10;
  localparam logic [5:0] UOP_PCADDU12I = 6'd11;

  localparam logic [5:0] UOP_CSRRD   = 6'd0,  UOP_CSRWR   = 6'd1,  UOP_CSRXCHG = 6'd2;
  localparam logic [5:0] UOP_RDCNTVL = 6'd3,  UOP_RDCNTVH = 6'd4,  UOP_RDCNTID = 6'd5;
  localparam logic [5:0] UOP_TLBSRCH = 6'd8,  UOP_TLBRD   = 6'd9,  UOP_TLBWR   = 6'd10;
  localparam logic [5:0] UOP_TLBFILL = 6'd11, UOP_ERTN    = 6'd12, UOP_INVTLB  = 6'd13;
  localparam logic [5:0] UOP_CACOP   = 6'd14, UOP_SYSCALL = 6'd16, UOP_BREAK   = 6'd17;

  localparam logic [5:0]  OP6_BEQ       = 6'h16;
  localparam logic [5:0]  OP6_BEQZ      = 6'h10;
  localparam logic [5:0]  OP6_B         = 6'h14;
  localparam logic [5:0]  OP6_JIRL      = 6'h13;
  localparam logic [5:0]  OP6_LU12I     = 6'h05;
  localparam logic [5:0]  OP6_PCADDU12I = 6'h07;
  localparam logic [5:0]  OP6_LS        = 6'h0a;
  localparam logic [7:0]  OP8_CSR       = 8'h04;
  localparam logic [16:0] BREAK_PREFIX  = 17'h00054;
  localparam logic [16:0] SYSCALL_PREFIX = 17'h00056;

  function automatic logic [3:0] alu_op4(input logic [5:0] uop);
    case (uop)
      UOP_SLTI:  return 4'b1000;
      UOP_SLTUI: return 4'b1001;
      UOP_ADDI:  return 4'b1010;
      UOP_ANDI:  return 4'b1101;
      UOP_ORI:   return 4'b1110;
      default:   return 4'b1111;
    endcase
  endfunction

  // True when v, read as two's complement, is representable in w bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
    logic signed [31:0] sh;
    sh = $signed(v) >>> (w - 1);
    return (sh == '0) || (sh == '1);
  endfunction

  function automatic logic fits_unsigned(input logic [31:0] v, input int unsigned w);
    return (v >> w) == '0;
  endfunction

endpackage

// File: rtl/encode_loongarch_comb.sv
// Combinational micro-op record to LA32R word encoder with BREAK substitution.
// ENCODE_LI_SPLIT_EN: wide ADDI from r0 becomes LU12I.W + ORI instead of a range fail.
module encode_loongarch_comb
  import la_isa_pkg::*;
#(
  parameter logic [14:0] BREAK_CODE = 15'd0
) (
  input  logic [6:0]  i_futype,
  input  logic [5:0]  i_uop,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_inst,
  output logic        o_err,
  output logic        o_split,
  output logic [31:0] o_lo_inst
);
  logic        w_ok;
  logic [31:0] w_inst;
  logic        w_s12_ok, w_u12_ok, w_u5_ok, w_csr_ok, w_hi_ok;
  logic        w_off16_ok, w_off21_ok, w_off26_ok;

  assign w_s12_ok   = fits_signed(i_imm, 12);
  assign w_u12_ok   = fits_unsigned(i_imm, 12);
  assign w_u5_ok    = fits_unsigned(i_imm, 5);
  assign w_csr_ok   = fits_unsigned(i_imm, 14);
  assign w_hi_ok    = (i_imm[11:0] == 12'd0);
  assign w_off16_ok = (i_imm[1:0] == 2'd0) && fits_signed(i_imm, 18);
  assign w_off21_ok = (i_imm[1:0] == 2'd0) && fits_signed(i_imm, 23);
  assign w_off26_ok = (i_imm[1:0] == 2'd0) && fits_signed(i_imm, 28);

  always_comb begin
    w_ok      = 1'b1;
    w_inst    = '0;
    o_split   = 1'b0;
    o_lo_inst = '0;
    unique case (i_futype)
      FT_ALU: begin
        case (i_uop)
          UOP_ADD, UOP_SUB, UOP_SLT, UOP_SLTU, UOP_NOR, UOP_AND, UOP_OR, UOP_XOR,
          UOP_SLL, UOP_SRL, UOP_SRA:
            w_inst = {10'b0, 2'b01, i_uop[4:0], i_rs2, i_rs1, i_rd};
          UOP_ADDI: begin
            w_inst = {6'b0, alu_op4(i_uop), i_imm[11:0], i_rs1, i_rd};
            w_ok   = w_s12_ok;
`ifdef ENCODE_LI_SPLIT_EN
            if (!w_s12_ok && (i_rs1 == 5'd0)) begin
              w_inst    = {OP6_LU12I, 1'b0, i_imm[31:12], i_rd};
              o_lo_inst = {6'b0, alu_op4(UOP_ORI), i_imm[11:0], i_rd, i_rd};
              o_split   = 1'b1;
              w_ok      = 1'b1;
            end
`endif
          end
          UOP_SLTI, UOP_SLTUI: begin
            w_inst = {6'b0, alu_op4(i_uop), i_imm[11:0], i_rs1, i_rd};
            w_ok   = w_s12_ok;
          end
          UOP_ANDI, UOP_ORI, UOP_XORI: begin
            w_inst = {6'b0, alu_op4(i_uop), i_imm[11:0], i_rs1, i_rd};
            w_ok   = w_u12_ok;
          end
          UOP_SLLI, UOP_SRLI, UOP_SRAI: begin
            w_inst = {6'b0, 4'b0001, 2'b00, i_uop[1:0], 3'b001, i_imm[4:0], i_rs1, i_rd};
            w_ok   = w_u5_ok;
          end
          UOP_LU12I: begin
            w_inst = {OP6_LU12I, 1'b0, i_imm[31:12], i_rd};
            w_ok   = w_hi_ok;
          end
          default: w_ok = 1'b0;
        endcase
      end
      FT_MDU: begin
        w_inst = {i_uop[2] ? 15'b10000 : 15'b1110, i_uop[1:0], i_rs2, i_rs1, i_rd};
        w_ok   = (i_uop[5:3] == 3'd0) && (i_uop[2] || (i_uop[1:0] != 2'b11));
      end
      FT_BR: begin
        case (i_uop)
          UOP_BEQ, 6'd1, 6'd2, 6'd3, 6'd4, UOP_BGEU: begin
            w_inst = {OP6_BEQ + i_uop, i_imm[17:2], i_rs1, i_rs2};
            w_ok   = w_off16_ok;
          end
          UOP_BEQZ, UOP_BNEZ: begin
            w_inst = {OP6_BEQZ + {5'd0, i_uop[0]}, i_imm[17:2], i_rs1, i_imm[22:18]};
            w_ok   = w_off21_ok;
          end
          UOP_B, UOP_BL: begin
            w_inst = {OP6_B + {5'd0, i_uop[0]}, i_imm[17:2], i_imm[27:18]};
            w_ok   = w_off26_ok;
          end
          UOP_JIRL: begin
            w_inst = {OP6_JIRL, i_imm[17:2], i_rs1, i_rd};
            w_ok   = w_off16_ok;
          end
          UOP_PCADDU12I: begin
            w_inst = {OP6_PCADDU12I, 1'b0, i_imm[31:12], i_rd};
            w_ok   = w_hi_ok;
          end
          default: w_ok = 1'b0;
        endcase
      end
      FT_LS: begin
        // uop: [5] store, [2] zero-extend, [1:0] size; unsigned word and unsigned store don't exist.
        w_inst = {OP6_LS, i_uop[2], i_uop[5], i_uop[1:0], i_imm[11:0], i_rs1,
                  i_uop[5] ? i_rs2 : i_rd};
        w_ok   = w_s12_ok && (i_uop[4:3] == 2'd0) && (i_uop[1:0] != 2'b11) &&
                 !(i_uop[2] && (i_uop[5] || i_uop[1]));
      end
      FT_CSR: begin
        case (i_uop)
          UOP_CSRRD:   begin w_inst = {OP8_CSR, i_imm[13:0], 5'd0, i_rd};  w_ok = w_csr_ok; end
          UOP_CSRWR:   begin w_inst = {OP8_CSR, i_imm[13:0], 5'd1, i_rs2}; w_ok = w_csr_ok; end
          UOP_CSRXCHG: begin
            w_inst = {OP8_CSR, i_imm[13:0], i_rs1, i_rs2};
            w_ok   = w_csr_ok && (i_rs1 > 5'd1);
          end
          UOP_RDCNTVL: w_inst = {22'h000018, 5'd0, i_rd};
          UOP_RDCNTVH: w_inst = {22'h000019, 5'd0, i_rd};
          UOP_RDCNTID: w_inst = {22'h000018, i_rd, 5'd0};
          UOP_TLBSRCH: w_inst = 32'h0648_2800;
          UOP_TLBRD:   w_inst = 32'h0648_2c00;
          UOP_TLBWR:   w_inst = 32'h0648_3000;
          UOP_TLBFILL: w_inst = 32'h0648_3400;
          UOP_ERTN:    w_inst = 32'h0648_3800;
          UOP_INVTLB:  begin w_inst = {17'h00c93, i_rs2, i_rs1, i_imm[4:0]}; w_ok = w_u5_ok; end
          UOP_CACOP:   begin w_inst = {10'h018, i_imm[11:0], i_rs1, i_rd};   w_ok = w_s12_ok; end
          UOP_SYSCALL: begin
            w_inst = {SYSCALL_PREFIX, i_imm[14:0]};
            w_ok   = fits_unsigned(i_imm, 15);
          end
          UOP_BREAK:   begin
            w_inst = {BREAK_PREFIX, i_imm[14:0]};
            w_ok   = fits_unsigned(i_imm, 15);
          end
          default: w_ok = 1'b0;
        endcase
      end
      default: w_ok = 1'b0;
    endcase
  end

  assign o_err  = ~w_ok;
  assign o_inst = w_ok ? w_inst : {BREAK_PREFIX, BREAK_CODE};

endmodule

// File: rtl/encode_loongarch.sv
// Streaming LA32R encoder: one-entry output register, split-word FSM, saturating error count.
// ENCODE_LI_SPLIT_EN enables the two-word LU12I.W/ORI expansion inside encode_loongarch_comb.
module encode_loongarch
  import la_isa_pkg::*;
#(
  parameter int unsigned ERR_CNT_W  = 16,
  parameter logic [14:0] BREAK_CODE = 15'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_futype,
  input  logic [5:0]           in_uop,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  logic [31:0]          w_inst, w_lo_inst;
  logic                 w_err, w_split, w_accept;
  enc_state_e           r_state;
  logic                 r_out_valid, r_out_err;
  logic [31:0]          r_out_inst, r_lo_inst;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  encode_loongarch_comb #(
    .BREAK_CODE(BREAK_CODE)
  ) u_comb (
    .i_futype (in_futype),
    .i_uop    (in_uop),
    .i_rd     (in_rd),
    .i_rs1    (in_rs1),
    .i_rs2    (in_rs2),
    .i_imm    (in_imm),
    .o_inst   (w_inst),
    .o_err    (w_err),
    .o_split  (w_split),
    .o_lo_inst(w_lo_inst)
  );

  assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_err   <= 1'b0;
      r_lo_inst   <= '0;
      r_err_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_inst  <= w_inst;
            r_out_err   <= w_err;
            if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            if (w_split) begin
              r_lo_inst <= w_lo_inst;
              r_state   <= S_SPLIT_LO;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        S_SPLIT_LO: begin
          // HI word is in the output register; LO replaces it once the consumer takes HI.
          if (out_ready) begin
            r_out_inst <= r_lo_inst;
            r_out_err  <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_inst  = r_out_inst;
  assign out_err   = r_out_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_encode_loongarch.sv
// Directed self-checking bench for encode_loongarch; expectations follow ENCODE_LI_SPLIT_EN.
module tb_encode_loongarch;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [6:0]  in_futype;
  logic [5:0]  in_uop;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_inst;
  logic [15:0] err_cnt;
  int          checks = 0;
  int          failures = 0;
  int          exp_err = 0;

  localparam logic [31:0] BRK = 32'h002A_0000;

  encode_loongarch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_futype(in_futype), .in_uop(in_uop), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] ft, input logic [5:0] uop, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    in_futype = ft; in_uop = uop; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid  = 1'b1;
  endtask

  // One accepted record: drive, clock once, drop valid, check the registered word.
  task automatic send(input string tag, input logic [6:0] ft, input logic [5:0] uop,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] exp_inst, input logic exp_e);
    drive(ft, uop, rd, rs1, rs2, imm);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (exp_e) exp_err++;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_inst"}, out_inst, exp_inst);
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_e});
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_futype = '0; in_uop = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_err", {31'd0, out_err}, 32'd0);
    chk("rst_cnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;

    drive(7'h01, 6'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("add_pre_valid", {31'd0, out_valid}, 32'd0);
    send("add", 7'h01, 6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0010_0823, 1'b0);
    send("addi_m1", 7'h01, 6'h20, 5'd4, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h02BF_FC04, 1'b0);
    send("beq", 7'h04, 6'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h5800_0822, 1'b0);
    send("sub", 7'h01, 6'd2, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0011_0823, 1'b0);
    send("ori", 7'h01, 6'h24, 5'd5, 5'd5, 5'd0, 32'h678, 32'h0399_E0A5, 1'b0);
    send("lu12i", 7'h01, 6'h30, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1424_68A5, 1'b0);
    send("ldw", 7'h08, 6'h02, 5'd4, 5'd3, 5'd0, 32'hFFFF_FFFC, 32'h28BF_F064, 1'b0);
    send("stw", 7'h08, 6'h22, 5'd0, 5'd3, 5'd7, 32'd8, 32'h2980_2067, 1'b0);
    send("mulw", 7'h02, 6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h001C_0823, 1'b0);
    send("b", 7'h04, 6'd8, 5'd0, 5'd0, 5'd0, 32'h100, 32'h5001_0000, 1'b0);
    send("beqz", 7'h04, 6'd6, 5'd0, 5'd4, 5'd0, 32'hFFFF_FFFC, 32'h43FF_FC9F, 1'b0);
    send("csrrd", 7'h10, 6'd0, 5'd4, 5'd0, 5'd0, 32'd5, 32'h0400_1404, 1'b0);
    send("si12_max", 7'h01, 6'h20, 5'd1, 5'd2, 5'd0, 32'd2047, 32'h029F_FC41, 1'b0);
    send("si12_min", 7'h01, 6'h20, 5'd1, 5'd2, 5'd0, 32'hFFFF_F800, 32'h02A0_0041, 1'b0);
    chk("cnt_clean", {16'd0, err_cnt}, 32'd0);

    send("bad_futype", 7'h03, 6'd0, 5'd1, 5'd1, 5'd1, 32'd0, BRK, 1'b1);
    chk("cnt_1", {16'd0, err_cnt}, 32'd1);
    send("beq_misalign", 7'h04, 6'd0, 5'd0, 5'd1, 5'd2, 32'd6, BRK, 1'b1);
    chk("cnt_2", {16'd0, err_cnt}, 32'd2);
    send("si12_over", 7'h01, 6'h20, 5'd1, 5'd2, 5'd0, 32'd2048, BRK, 1'b1);
    send("unit5", 7'h20, 6'd0, 5'd1, 5'd1, 5'd1, 32'd0, BRK, 1'b1);
    chk("cnt_4", {16'd0, err_cnt}, exp_err);

`ifdef ENCODE_LI_SPLIT_EN
    send("split_hi", 7'h01, 6'h20, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 32'h1424_68A5, 1'b0);
    chk("split_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("split_lo_valid", {31'd0, out_valid}, 32'd1);
    chk("split_lo_inst", out_inst, 32'h0399_E0A5);
    chk("split_lo_err", {31'd0, out_err}, 32'd0);
    chk("split_done_ready", {31'd0, in_ready}, 32'd1);
`else
    send("nosplit", 7'h01, 6'h20, 5'd5, 5'd0, 5'd0, 32'h1234_5678, BRK, 1'b1);
`endif
    chk("cnt_split", {16'd0, err_cnt}, exp_err);

    // Back-pressure: word A held while B waits, then B appears exactly once.
    send("bp_a", 7'h01, 6'd5, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0012_8C41, 1'b0);
    out_ready = 1'b0;
    drive(7'h01, 6'd11, 5'd6, 5'd7, 5'd8, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_inst", out_inst, 32'h0012_8C41);
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_b_inst", out_inst, 32'h0015_A0E6);
    chk("bp_b_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("bp_b_once", {31'd0, out_valid}, 32'd0);

    // Reset with a split pending (or a plain error word in the default build).
`ifdef ENCODE_LI_SPLIT_EN
    send("rst_split_hi", 7'h01, 6'h20, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 32'h1424_68A5, 1'b0);
`else
    send("rst_split_hi", 7'h01, 6'h20, 5'd5, 5'd0, 5'd0, 32'h1234_5678, BRK, 1'b1);
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_inst", out_inst, 32'd0);
    chk("rst_mid_cnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("rst_no_lo", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
